// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a small FIFO and a
// serializer drains it; STATUS reports FIFO/transmitter state combinationally.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        memwrite,
  input  logic        memread,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        tx,
  output logic        irq_empty
);
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] DEPTH     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            ovf;
  logic [15:0]     baud;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  logic empty, full, busy, push_req, push, pop, clr_ovf, baud_done;
  logic [7:0] head;
  logic unused_bits;

  assign sel       = (addr[31:3] == BASE_ADDR[31:3]);
  assign empty     = (count == '0);
  assign full      = (count == DEPTH);
  assign busy      = (state != IDLE);
  assign push_req  = memwrite & sel & ~addr[2];
  assign push      = push_req & ~full;
  assign clr_ovf   = memwrite & sel & addr[2] & wdata[3];
  assign baud_done = (baud == BAUD_LAST);
  assign pop       = ~empty & ((state == IDLE) | ((state == STOP) & baud_done));
  assign head      = mem[rd_ptr];
  assign irq_empty = empty & (state == IDLE);
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  always_comb begin
    rdata = '0;
    if (memread & sel & addr[2])
      rdata = {16'h0, 8'(count), 4'h0, ovf, busy, empty, full};
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wdata[7:0];
  end

  // Full is judged before the edge, so a concurrent pop never rescues a store.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push_req & full) ovf <= 1'b1;
      else if (clr_ovf)    ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud <= '0;
          tx   <= 1'b1;
          if (pop) begin
            shift <= head;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= shift[0];
          end else baud <= baud + 16'd1;
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else baud <= baud + 16'd1;
        end
        STOP: begin
          if (baud_done) begin
            baud <= '0;
            // Chain straight into the next start bit so frames stay contiguous.
            if (pop) begin
              shift <= head;
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else baud <= baud + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level model (byte queue + frame position)
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam int          FRAME = 10 * CPB;

  logic        CLK, reset;
  logic [31:0] addr, wdata, rdata;
  logic        memwrite, memread, sel, tx, irq_empty;

  int tests = 0;
  int fails = 0;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .reset(reset), .addr(addr), .wdata(wdata), .memwrite(memwrite),
    .memread(memread), .rdata(rdata), .sel(sel), .tx(tx), .irq_empty(irq_empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: queue of accepted bytes and position within the frame on the line.
  logic [7:0] q[$];
  bit         m_active, m_ovf, m_pop;
  int         m_pos, m_sz;
  logic [7:0] m_cur;

  function automatic logic exp_sel(input logic [31:0] a);
    return a[31:3] == BASE[31:3];
  endfunction

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (memread && exp_sel(addr) && addr[2])
      return {16'h0, 8'(q.size()), 4'h0, m_ovf, m_active, q.size() == 0, q.size() == DEPTH};
    return 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK or negedge reset);
      if (!reset) begin
        q.delete();
        m_active = 0; m_pos = 0; m_ovf = 0;
      end else begin
        m_sz  = q.size();
        m_pop = 0;
        if (m_active && m_pos < FRAME - 1) m_pos++;
        else if (m_sz > 0) begin
          m_pop = 1; m_active = 1; m_pos = 0; m_cur = q[0];
        end else begin
          m_active = 0; m_pos = 0;
        end
        if (m_pop) void'(q.pop_front());
        if (memwrite && exp_sel(addr)) begin
          if (!addr[2]) begin
            if (m_sz == DEPTH) m_ovf = 1;
            else q.push_back(wdata[7:0]);
          end else if (wdata[3]) m_ovf = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (reset) begin
        chk("tx", 32'(tx), 32'(exp_tx()));
        chk("irq_empty", 32'(irq_empty), 32'(q.size() == 0 && !m_active));
        chk("sel", 32'(sel), 32'(exp_sel(addr)));
        chk("rdata", rdata, exp_rdata());
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic chk_read(input string name, input logic [31:0] a,
                          input logic [31:0] exp, input logic exp_s);
    addr = a; memread = 1'b1;
    #1;
    chk(name, rdata, exp);
    chk({name, "_sel"}, 32'(sel), 32'(exp_s));
    memread = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while ((m_active || q.size() != 0) && i < 1000) begin
      tick();
      i++;
    end
    tests++;
    if (i >= 1000) begin
      fails++;
      $display("FAIL %s: drain timeout after %0d cycles", name, i);
    end
    chk({name, "_irq"}, 32'(irq_empty), 32'h1);
  endtask

  logic [31:0] addrs [6];
  logic [9:0]  a5_bits;

  initial begin
    addrs = '{BASE, BASE + 32'd4, BASE + 32'd8, BASE - 32'd4, BASE + 32'd1, BASE + 32'd6};
    reset = 1'b0; addr = '0; wdata = '0; memwrite = 1'b0; memread = 1'b0;
    repeat (3) @(posedge CLK);
    #2 reset = 1'b1;
    tick();

    // Reset mid-frame: line must go high at once
    store(BASE, 32'h0);
    repeat (10) tick();
    chk("tx_low_midframe", 32'(tx), 32'h0);
    reset = 1'b0;
    #1;
    chk("tx_reset", 32'(tx), 32'h1);
    chk("irq_reset", 32'(irq_empty), 32'h1);
    chk("rdata_reset", rdata, 32'h0);
    tick();
    reset = 1'b1;
    chk_read("status_reset", BASE + 32'd4, 32'h0000_0002, 1'b1);
    tick();

    // Single byte 0xA5: literal bit sequence
    a5_bits = 10'b11_0100_1010;
    store(BASE, 32'hDEAD_BEA5);
    chk("irq_pending", 32'(irq_empty), 32'h0);
    tick();
    for (int k = 0; k < 10; k++) begin
      repeat (2) tick();
      chk($sformatf("a5_bit%0d", k), 32'(tx), 32'(a5_bits[k]));
      repeat (2) tick();
    end
    chk("irq_after_frame", 32'(irq_empty), 32'h1);
    chk_read("status_idle", BASE + 32'd4, 32'h0000_0002, 1'b1);

    // Burst of three, contiguous frames
    store(BASE, 32'h41);
    store(BASE, 32'h42);
    store(BASE, 32'h43);
    chk_read("burst_count2", BASE + 32'd4, 32'h0000_0204, 1'b1);
    repeat (38) tick();
    chk("burst_stop", 32'(tx), 32'h1);
    tick();
    chk("burst_next_start", 32'(tx), 32'h0);
    chk_read("burst_count1", BASE + 32'd4, 32'h0000_0104, 1'b1);
    drain("burst");

    // Overflow: 10 stores, first popped, 8 fit, 10th dropped
    for (int i = 0; i < 10; i++) store(BASE, 32'h50 + 32'(i));
    chk_read("ovf_status", BASE + 32'd4, 32'h0000_080D, 1'b1);
    store(BASE + 32'd4, 32'h8);
    chk_read("ovf_cleared", BASE + 32'd4, 32'h0000_0805, 1'b1);
    drain("overflow");

    // Push and pop on the same edge at end of STOP
    store(BASE, 32'h11);
    store(BASE, 32'h22);
    repeat (39) tick();
    chk_read("pp_before", BASE + 32'd4, 32'h0000_0104, 1'b1);
    store(BASE, 32'h33);
    chk_read("pp_after", BASE + 32'd4, 32'h0000_0104, 1'b1);
    drain("pushpop");

    // Decode window
    chk_read("dec_plus8", BASE + 32'd8, 32'h0, 1'b0);
    chk_read("dec_minus4", BASE - 32'd4, 32'h0, 1'b0);
    tick();
    store(BASE + 32'd8, 32'h77);
    store(BASE - 32'd4, 32'h78);
    chk_read("dec_status", BASE + 32'd7, 32'h0000_0002, 1'b1);
    chk_read("dec_txdata", BASE, 32'h0, 1'b1);
    repeat (3) tick();

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      addr     = addrs[$urandom_range(0, 5)];
      wdata    = $urandom;
      memwrite = ($urandom_range(0, 3) == 0);
      memread  = 1'($urandom_range(0, 1));
      tick();
    end
    memwrite = 1'b0; memread = 1'b0;
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's data-memory bus, downstream of the single-cycle core; consumes the same store/load traffic the data RAM sees (ALU address, rs2 write data, memread/memwrite).
- Claims a small address window.
- Stores to TXDATA are queued in a FIFO and serialized as 8N1 frames on tx.
- Loads from STATUS return FIFO and transmitter state combinationally, matching RAM read timing.

Parameters:
- BASE_ADDR, 32'h0001_0000, byte address of TXDATA; STATUS at BASE_ADDR+4; word aligned.
- CLKS_PER_BIT, 868, CLK cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.

Ports:
- CLK  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  32  data-bus byte address (ALU result).
- wdata  in  32  store data (rs2).
- memwrite  in  1  store strobe, sampled at rising CLK.
- memread  in  1  load strobe.
- rdata  out  32  load data; combinational.
- sel  out  1  addr[31:3] == BASE_ADDR[31:3]; core muxes rdata over RAM data when set.
- tx  out  1  serial line, idle high.
- irq_empty  out  1  high when FIFO empty and serializer IDLE.

Behaviour:
- Reset (reset=0, asynchronous): FIFO cleared (count=0, pointers 0), overflow flag 0, FSM=IDLE, tx=1, irq_empty=1, rdata=0. Reset mid-frame aborts the frame immediately; tx returns to 1 with no glitch low.
- Decode is on addr[2]: 0=TXDATA, 1=STATUS. addr[1:0] is ignored.
- Store, TXDATA (memwrite & sel & addr[2]==0):
  - At the CLK edge, pushes wdata[7:0]; wdata[31:8] is ignored.
  - Store width is irrelevant.
- Store to a full FIFO:
  - "Full" is count==FIFO_DEPTH before the edge.
  - The byte is dropped and the overflow flag is set (sticky).
  - This holds even if a pop occurs on the same edge.
- Store, STATUS: if wdata[3]==1, clears overflow. All other bits are ignored.
- Load (memread & sel), combinational:
  - TXDATA reads 0.
  - STATUS reads {count zero-extended in [15:8], 4'b0, overflow[3], busy[2], empty[1], full[0]}.
  - rdata=0 when !(memread & sel).
- Simultaneous push and pop on a non-full FIFO: both occur, count unchanged, order preserved.
- Pointers wrap modulo FIFO_DEPTH.
- Serializer FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: tx=1. If FIFO non-empty, pop head into an 8-bit shift register; next state START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx=shift[0], LSB first. Shift every CLKS_PER_BIT cycles; bit index 0..7. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the final cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency:
  - A byte pushed at edge N into an empty, idle block is popped at edge N+1.
  - tx falls after edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are contiguous.
- busy=1 in any state other than IDLE.
- irq_empty is registered-state derived: empty & (state==IDLE).
- The baud counter is 16 bits. It reloads to 0 on every state/bit transition, so there is no drift across frames.
- Loads and stores outside the window have no effect and sel=0.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4: assert reset=0 mid-frame, release -> tx=1 immediately; STATUS read = 32'h0000_0002; irq_empty=1.
- Single byte: store 32'hDEAD_BEA5 to BASE_ADDR -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; tx low starts one cycle after the store edge; irq_empty returns to 1 after 40 cycles.
- Burst of 3 stores (0x41, 0x42, 0x43) on consecutive cycles -> STATUS count reads 2 then 1 as frames start; 120 contiguous cycles of framing; no idle-high gap between stop and next start.
- Overflow, FIFO_DEPTH=8: 10 consecutive stores while the first frame is in progress. First byte is popped; 8 fit, 1 is dropped.
  - STATUS shows full=1, overflow=1, count=8.
  - Store 32'h8 to BASE_ADDR+4 -> overflow=0.
  - Transmitted bytes are pushes 1..9 in order; the 10th is absent.
- Push/pop same edge: store timed to the cycle the STOP state pops with the FIFO holding 1 entry -> count stays 1; byte order preserved on tx.
- Decode: load/store at BASE_ADDR+8 and BASE_ADDR-4 -> sel=0, rdata=0, FIFO unchanged. Load BASE_ADDR -> rdata=0 with sel=1.
